// File: rtl/dmem_pkg.sv
// Shared types for the AXI4-lite data-memory slave: response codes and FSM state encodings.
package dmem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_READ,
        R_RESP
    } r_state_t;

endpackage

// File: rtl/dmem_ram.sv
// Word-organised RAM with byte-enable write port and registered read port.
// A read and write of the same word on one edge returns the old contents.
module dmem_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_wstrb,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [0:(1<<ADDR_W)-1];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_wstrb[i]) begin
                    r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_axi_slave.sv
// AXI4-lite slave data memory: one outstanding write and one outstanding read, independent channels.
// Optional DMEM_RANGE_CHECK_EN answers SLVERR for addresses outside the mapped window.
module dmem_axi_slave
    import dmem_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_awaddr,
    input  logic [2:0]  axi_awprot,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    output logic [1:0]  axi_bresp,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [31:0] axi_araddr,
    input  logic [2:0]  axi_arprot,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp
);

    w_state_t    r_wstate, w_wnext;
    r_state_t    r_rstate, w_rnext;
    logic [31:0] r_awaddr, r_wdata, r_rdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_bresp, r_rresp;
    logic        r_rerr;

    logic        w_aw_hs, w_w_hs, w_ar_hs, w_do_write, w_werr, w_rerr, w_unused;
    logic [31:0] w_waddr, w_wdata_eff, w_woff, w_roff, w_ram_rdata;
    logic [3:0]  w_wstrb_eff;

    assign w_aw_hs = axi_awvalid & axi_awready;
    assign w_w_hs  = axi_wvalid & axi_wready;
    assign w_ar_hs = axi_arvalid & axi_arready;

    // The write commits on the edge where the second half arrives, using bus data for that half.
    assign w_do_write  = (w_aw_hs | (r_wstate == W_HAVE_AW)) & (w_w_hs | (r_wstate == W_HAVE_W));
    assign w_waddr     = w_aw_hs ? axi_awaddr : r_awaddr;
    assign w_wdata_eff = w_w_hs ? axi_wdata : r_wdata;
    assign w_wstrb_eff = w_w_hs ? axi_wstrb : r_wstrb;
    assign w_woff      = w_waddr - BASE_ADDR;
    assign w_roff      = axi_araddr - BASE_ADDR;

`ifdef DMEM_RANGE_CHECK_EN
    assign w_werr   = |w_woff[31:ADDR_W+2];
    assign w_rerr   = |w_roff[31:ADDR_W+2];
    assign w_unused = ^{axi_awprot, axi_arprot, w_woff[1:0], w_roff[1:0]};
`else
    assign w_werr   = 1'b0;
    assign w_rerr   = 1'b0;
    assign w_unused = ^{axi_awprot, axi_arprot, w_woff[1:0], w_roff[1:0],
                        w_woff[31:ADDR_W+2], w_roff[31:ADDR_W+2]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wnext;
            r_rstate <= w_rnext;
        end
    end

    always_comb begin
        w_wnext = r_wstate;
        case (r_wstate)
            W_IDLE: begin
                if (w_do_write)   w_wnext = W_RESP;
                else if (w_aw_hs) w_wnext = W_HAVE_AW;
                else if (w_w_hs)  w_wnext = W_HAVE_W;
            end
            W_HAVE_AW: if (w_w_hs)     w_wnext = W_RESP;
            W_HAVE_W:  if (w_aw_hs)    w_wnext = W_RESP;
            W_RESP:    if (axi_bready) w_wnext = W_IDLE;
            default:   w_wnext = W_IDLE;
        endcase
    end

    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs)    w_rnext = R_READ;
            R_READ:                  w_rnext = R_RESP;
            R_RESP:  if (axi_rready) w_rnext = R_IDLE;
            default:                 w_rnext = R_IDLE;
        endcase
    end

    always_comb begin
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        case (r_wstate)
            W_IDLE:    begin axi_awready = 1'b1; axi_wready = 1'b1; end
            W_HAVE_AW: axi_wready  = 1'b1;
            W_HAVE_W:  axi_awready = 1'b1;
            W_RESP:    axi_bvalid  = 1'b1;
            default:   ;
        endcase
        axi_arready = (r_rstate == R_IDLE);
        axi_rvalid  = (r_rstate == R_RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= RESP_OKAY;
            r_rerr   <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            if (w_aw_hs) r_awaddr <= axi_awaddr;
            if (w_w_hs) begin
                r_wdata <= axi_wdata;
                r_wstrb <= axi_wstrb;
            end
            if (w_do_write) r_bresp <= w_werr ? RESP_SLVERR : RESP_OKAY;
            if (w_ar_hs)    r_rerr  <= w_rerr;
            if (r_rstate == R_READ) begin
                r_rdata <= r_rerr ? 32'h0 : w_ram_rdata;
                r_rresp <= r_rerr ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // rst_n gating keeps a handshake seen during reset from touching the array.
    dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .i_we    (w_do_write & ~w_werr & rst_n),
        .i_waddr (w_woff[ADDR_W+1:2]),
        .i_wdata (w_wdata_eff),
        .i_wstrb (w_wstrb_eff),
        .i_re    (w_ar_hs),
        .i_raddr (w_roff[ADDR_W+1:2]),
        .o_rdata (w_ram_rdata)
    );

    assign axi_bresp = r_bresp;
    assign axi_rdata = r_rdata;
    assign axi_rresp = r_rresp;

endmodule

// File: tb/tb_dmem_axi_slave.sv
// Directed testbench for dmem_axi_slave; covers ordering, stalls, collisions, reset and range handling.
module tb_dmem_axi_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        axi_awvalid = 1'b0, axi_awready;
    logic [31:0] axi_awaddr = '0;
    logic        axi_wvalid = 1'b0, axi_wready;
    logic [31:0] axi_wdata = '0;
    logic [3:0]  axi_wstrb = '0;
    logic        axi_bvalid, axi_bready = 1'b0;
    logic [1:0]  axi_bresp;
    logic        axi_arvalid = 1'b0, axi_arready;
    logic [31:0] axi_araddr = '0;
    logic        axi_rvalid, axi_rready = 1'b0;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;

    int n_vec = 0;
    int n_err = 0;

    dmem_axi_slave dut (
        .clk(clk), .rst_n(rst_n),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr), .axi_awprot(3'b000),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arprot(3'b000),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_b(output logic [1:0] resp);
        int n = 0;
        while (!axi_bvalid && n < 10) begin tick(); n++; end
        if (!axi_bvalid) begin
            n_vec++; n_err++;
            $display("FAIL b_timeout: bvalid got=0 expected=1");
        end
        resp = axi_bresp;
        axi_bready = 1'b1;
        tick();
        axi_bready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        axi_awvalid = 1'b1; axi_awaddr = addr;
        axi_wvalid  = 1'b1; axi_wdata  = data; axi_wstrb = strb;
        tick();
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        wait_b(resp);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        axi_arvalid = 1'b1; axi_araddr = addr;
        tick();
        axi_arvalid = 1'b0;
        while (!axi_rvalid && n < 10) begin tick(); n++; end
        if (!axi_rvalid) begin
            n_vec++; n_err++;
            $display("FAIL r_timeout: rvalid got=0 expected=1");
        end
        data = axi_rdata;
        resp = axi_rresp;
        axi_rready = 1'b1;
        tick();
        axi_rready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_vec++; if (axi_awready !== 1'b1) begin n_err++; $display("FAIL rst_awready got=%b expected=1", axi_awready); end
        n_vec++; if (axi_wready  !== 1'b1) begin n_err++; $display("FAIL rst_wready got=%b expected=1", axi_wready); end
        n_vec++; if (axi_arready !== 1'b1) begin n_err++; $display("FAIL rst_arready got=%b expected=1", axi_arready); end
        n_vec++; if (axi_bvalid  !== 1'b0) begin n_err++; $display("FAIL rst_bvalid got=%b expected=0", axi_bvalid); end
        n_vec++; if (axi_rvalid  !== 1'b0) begin n_err++; $display("FAIL rst_rvalid got=%b expected=0", axi_rvalid); end
        n_vec++; if (axi_bresp   !== 2'b00) begin n_err++; $display("FAIL rst_bresp got=%b expected=00", axi_bresp); end
        n_vec++; if (axi_rresp   !== 2'b00) begin n_err++; $display("FAIL rst_rresp got=%b expected=00", axi_rresp); end
        n_vec++; if (axi_rdata   !== 32'h0) begin n_err++; $display("FAIL rst_rdata got=%h expected=0", axi_rdata); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_same_cycle();
        axi_bready  = 1'b1;
        axi_awvalid = 1'b1; axi_awaddr = 32'h10;
        axi_wvalid  = 1'b1; axi_wdata  = 32'hDEADBEEF; axi_wstrb = 4'hF;
        tick();
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        n_vec++; if (axi_bvalid !== 1'b1) begin n_err++; $display("FAIL same_bvalid got=%b expected=1", axi_bvalid); end
        n_vec++; if (axi_bresp !== 2'b00) begin n_err++; $display("FAIL same_bresp got=%b expected=00", axi_bresp); end
        tick();
        axi_bready = 1'b0;
        n_vec++; if (axi_bvalid !== 1'b0) begin n_err++; $display("FAIL same_bdone got=%b expected=0", axi_bvalid); end
        axi_arvalid = 1'b1; axi_araddr = 32'h10;
        tick();
        axi_arvalid = 1'b0;
        n_vec++; if (axi_rvalid !== 1'b0) begin n_err++; $display("FAIL same_rvalid_early got=%b expected=0", axi_rvalid); end
        tick();
        n_vec++; if (axi_rvalid !== 1'b1) begin n_err++; $display("FAIL same_rvalid got=%b expected=1", axi_rvalid); end
        n_vec++; if (axi_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL same_rdata got=%h expected=deadbeef", axi_rdata); end
        n_vec++; if (axi_rresp !== 2'b00) begin n_err++; $display("FAIL same_rresp got=%b expected=00", axi_rresp); end
        axi_rready = 1'b1;
        tick();
        axi_rready = 1'b0;
        n_vec++; if (axi_rvalid !== 1'b0) begin n_err++; $display("FAIL same_rdone got=%b expected=0", axi_rvalid); end
        n_vec++; if (axi_arready !== 1'b1) begin n_err++; $display("FAIL same_arready got=%b expected=1", axi_arready); end
    endtask

    task automatic test_w_before_aw();
        logic [1:0]  br, rr;
        logic [31:0] rd;
        do_write(32'h20, 32'h11223344, 4'hF, br);
        axi_wvalid = 1'b1; axi_wdata = 32'h000000AA; axi_wstrb = 4'h1;
        tick();
        axi_wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_vec++; if (axi_wready !== 1'b0) begin n_err++; $display("FAIL wfirst_wready got=%b expected=0", axi_wready); end
            n_vec++; if (axi_awready !== 1'b1) begin n_err++; $display("FAIL wfirst_awready got=%b expected=1", axi_awready); end
            n_vec++; if (axi_bvalid !== 1'b0) begin n_err++; $display("FAIL wfirst_bvalid_early got=%b expected=0", axi_bvalid); end
            tick();
        end
        axi_awvalid = 1'b1; axi_awaddr = 32'h20;
        tick();
        axi_awvalid = 1'b0;
        n_vec++; if (axi_bvalid !== 1'b1) begin n_err++; $display("FAIL wfirst_bvalid got=%b expected=1", axi_bvalid); end
        wait_b(br);
        n_vec++; if (br !== 2'b00) begin n_err++; $display("FAIL wfirst_bresp got=%b expected=00", br); end
        do_read(32'h20, rd, rr);
        n_vec++; if (rd !== 32'h112233AA) begin n_err++; $display("FAIL wfirst_rdata got=%h expected=112233aa", rd); end
    endtask

    task automatic test_b_stall();
        logic [1:0]  rr;
        logic [31:0] rd;
        axi_bready  = 1'b0;
        axi_awvalid = 1'b1; axi_awaddr = 32'h30;
        axi_wvalid  = 1'b1; axi_wdata  = 32'h55; axi_wstrb = 4'hF;
        tick();
        axi_awaddr = 32'h34; axi_wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (axi_bvalid !== 1'b1) begin n_err++; $display("FAIL bstall_bvalid got=%b expected=1", axi_bvalid); end
            n_vec++; if (axi_bresp !== 2'b00) begin n_err++; $display("FAIL bstall_bresp got=%b expected=00", axi_bresp); end
            n_vec++; if (axi_awready !== 1'b0) begin n_err++; $display("FAIL bstall_awready got=%b expected=0", axi_awready); end
            tick();
        end
        axi_bready = 1'b1;
        tick();
        n_vec++; if (axi_bvalid !== 1'b0) begin n_err++; $display("FAIL bstall_bdone got=%b expected=0", axi_bvalid); end
        n_vec++; if (axi_awready !== 1'b1) begin n_err++; $display("FAIL bstall_awready_after got=%b expected=1", axi_awready); end
        axi_wvalid = 1'b1; axi_wdata = 32'h66; axi_wstrb = 4'hF;
        tick();
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        n_vec++; if (axi_bvalid !== 1'b1) begin n_err++; $display("FAIL bstall_second_bvalid got=%b expected=1", axi_bvalid); end
        tick();
        axi_bready = 1'b0;
        do_read(32'h34, rd, rr);
        n_vec++; if (rd !== 32'h66) begin n_err++; $display("FAIL bstall_rd34 got=%h expected=00000066", rd); end
        do_read(32'h30, rd, rr);
        n_vec++; if (rd !== 32'h55) begin n_err++; $display("FAIL bstall_rd30 got=%h expected=00000055", rd); end
    endtask

    task automatic test_collision();
        logic [1:0]  br, rr;
        logic [31:0] rd;
        do_write(32'h40, 32'h1, 4'hF, br);
        axi_bready  = 1'b1;
        axi_arvalid = 1'b1; axi_araddr = 32'h40;
        axi_awvalid = 1'b1; axi_awaddr = 32'h40;
        axi_wvalid  = 1'b1; axi_wdata  = 32'h2; axi_wstrb = 4'hF;
        tick();
        axi_arvalid = 1'b0; axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        n_vec++; if (axi_bvalid !== 1'b1) begin n_err++; $display("FAIL coll_bvalid got=%b expected=1", axi_bvalid); end
        tick();
        axi_bready = 1'b0;
        n_vec++; if (axi_rvalid !== 1'b1) begin n_err++; $display("FAIL coll_rvalid got=%b expected=1", axi_rvalid); end
        n_vec++; if (axi_rdata !== 32'h1) begin n_err++; $display("FAIL coll_old_data got=%h expected=00000001", axi_rdata); end
        axi_rready = 1'b1;
        tick();
        axi_rready = 1'b0;
        do_read(32'h40, rd, rr);
        n_vec++; if (rd !== 32'h2) begin n_err++; $display("FAIL coll_new_data got=%h expected=00000002", rd); end
    endtask

    task automatic test_strobes();
        logic [1:0]  br, rr;
        logic [31:0] rd;
        do_write(32'h20, 32'hBBCC0000, 4'b1100, br);
        do_read(32'h20, rd, rr);
        n_vec++; if (rd !== 32'hBBCC33AA) begin n_err++; $display("FAIL strb_half got=%h expected=bbcc33aa", rd); end
        do_write(32'h20, 32'hFFFFFFFF, 4'b0000, br);
        n_vec++; if (br !== 2'b00) begin n_err++; $display("FAIL strb_zero_bresp got=%b expected=00", br); end
        do_read(32'h20, rd, rr);
        n_vec++; if (rd !== 32'hBBCC33AA) begin n_err++; $display("FAIL strb_zero_data got=%h expected=bbcc33aa", rd); end
    endtask

    task automatic test_reset_mid_read();
        axi_arvalid = 1'b1; axi_araddr = 32'h10;
        tick();
        axi_arvalid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (axi_rvalid !== 1'b1) begin n_err++; $display("FAIL rstall_rvalid got=%b expected=1", axi_rvalid); end
            n_vec++; if (axi_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rstall_rdata got=%h expected=deadbeef", axi_rdata); end
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (axi_rvalid !== 1'b0) begin n_err++; $display("FAIL rrst_rvalid got=%b expected=0", axi_rvalid); end
        n_vec++; if (axi_rdata !== 32'h0) begin n_err++; $display("FAIL rrst_rdata got=%h expected=0", axi_rdata); end
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++; if (axi_arready !== 1'b1) begin n_err++; $display("FAIL rrst_arready got=%b expected=1", axi_arready); end
        n_vec++; if (axi_rvalid !== 1'b0) begin n_err++; $display("FAIL rrst_rvalid_after got=%b expected=0", axi_rvalid); end
    endtask

    task automatic test_reset_mid_write();
        logic [1:0]  br, rr;
        logic [31:0] rd;
        do_write(32'h60, 32'h12345678, 4'hF, br);
        axi_wvalid = 1'b1; axi_wdata = 32'h99; axi_wstrb = 4'hF;
        tick();
        axi_wvalid = 1'b0;
        n_vec++; if (axi_wready !== 1'b0) begin n_err++; $display("FAIL wrst_wready_held got=%b expected=0", axi_wready); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (axi_wready !== 1'b1) begin n_err++; $display("FAIL wrst_wready got=%b expected=1", axi_wready); end
        tick();
        rst_n = 1'b1;
        axi_awvalid = 1'b1; axi_awaddr = 32'h60;
        tick();
        axi_awvalid = 1'b0;
        tick();
        n_vec++; if (axi_bvalid !== 1'b0) begin n_err++; $display("FAIL wrst_bvalid got=%b expected=0", axi_bvalid); end
        axi_wvalid = 1'b1; axi_wdata = 32'hABCD0000; axi_wstrb = 4'b1100;
        tick();
        axi_wvalid = 1'b0;
        wait_b(br);
        do_read(32'h60, rd, rr);
        n_vec++; if (rd !== 32'hABCD5678) begin n_err++; $display("FAIL wrst_data got=%h expected=abcd5678", rd); end
    endtask

    task automatic test_range();
        logic [1:0]  br, rr;
        logic [31:0] rd;
        do_write(32'h0, 32'hA5A5A5A5, 4'hF, br);
`ifdef DMEM_RANGE_CHECK_EN
        do_write(32'h4000, 32'hFFFFFFFF, 4'hF, br);
        n_vec++; if (br !== 2'b10) begin n_err++; $display("FAIL range_bresp got=%b expected=10", br); end
        do_read(32'h0, rd, rr);
        n_vec++; if (rd !== 32'hA5A5A5A5) begin n_err++; $display("FAIL range_word0 got=%h expected=a5a5a5a5", rd); end
        do_read(32'h4000, rd, rr);
        n_vec++; if (rr !== 2'b10) begin n_err++; $display("FAIL range_rresp got=%b expected=10", rr); end
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL range_rdata got=%h expected=0", rd); end
`else
        do_write(32'h4000, 32'h5A5A5A5A, 4'hF, br);
        n_vec++; if (br !== 2'b00) begin n_err++; $display("FAIL wrap_bresp got=%b expected=00", br); end
        do_read(32'h0, rd, rr);
        n_vec++; if (rd !== 32'h5A5A5A5A) begin n_err++; $display("FAIL wrap_word0 got=%h expected=5a5a5a5a", rd); end
        n_vec++; if (rr !== 2'b00) begin n_err++; $display("FAIL wrap_rresp got=%b expected=00", rr); end
`endif
    endtask

    initial begin
        test_reset();
        test_same_cycle();
        test_w_before_aw();
        test_b_stall();
        test_collision();
        test_strobes();
        test_reset_mid_read();
        test_reset_mid_write();
        test_range();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_axi_slave.md
Name: dmem_axi_slave

Overview:
- AXI4-lite slave data memory: the downstream consumer of the CPU core's load/store AXI4-lite master port.
- Serves word-aligned loads and byte/half/word stores (via strobes) from a single-port-per-channel synchronous RAM array.
- Strictly one outstanding write and one outstanding read; read and write channels are independent.

Parameters:
- ADDR_W, 12, word-address width; memory holds 2**ADDR_W 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- axi_awvalid  in  1  write address valid
- axi_awready  out  1  write address ready
- axi_awaddr  in  32  write byte address
- axi_awprot  in  3  ignored
- axi_wvalid  in  1  write data valid
- axi_wready  out  1  write data ready
- axi_wdata  in  32  write data
- axi_wstrb  in  4  byte strobes
- axi_bvalid  out  1  write response valid
- axi_bready  in  1  write response ready
- axi_bresp  out  2  write response
- axi_arvalid  in  1  read address valid
- axi_arready  out  1  read address ready
- axi_araddr  in  32  read byte address
- axi_arprot  in  3  ignored
- axi_rvalid  out  1  read data valid
- axi_rready  in  1  read data ready
- axi_rdata  out  32  read data
- axi_rresp  out  2  read response

Behaviour:
- Reset (async assert, sync release): awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=OKAY, rresp=OKAY, rdata=0. RAM contents are not reset.
- Word index = (addr - BASE_ADDR)[ADDR_W+1:2]. Bits [1:0] are ignored; the master supplies lane-aligned data and strobes.
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - AW and W are accepted in either order or in the same cycle. Each handshake latches its payload and drops that channel's ready.
  - When both are held (same-cycle acceptance included), the RAM write happens on the next edge: byte lane i is written iff wstrb[i]. At that same edge bvalid rises (state W_RESP).
  - Total latency: bvalid is high 1 cycle after the later of the two handshakes.
  - bvalid holds until bready. On the handshake edge, awready=wready=1 and the FSM returns to W_IDLE.
  - awready/wready stay 0 while bvalid=1; no new write is accepted until B completes.
  - wstrb=4'b0000 still produces an OKAY response but modifies no bytes.
- Read FSM states: R_IDLE (arready=1), R_READ, R_RESP.
  - AR handshake at edge N issues the RAM read → R_READ. Edge N+1 registers the data: rvalid=1, rdata valid (R_RESP).
  - rvalid/rdata stay stable until rready. The handshake edge returns the FSM to R_IDLE with arready=1.
  - Back-to-back read throughput is therefore one read per 3 cycles minimum.
- Read/write collision: if a RAM write and a RAM read of the same word occur on the same edge, the read returns the old data (read-first).
- A write whose RAM update precedes the read's AR handshake is always visible to that read.
- AXI stability: a slave output valid never drops without its handshake. Inputs are sampled only at handshake.
- Reset asserted mid-transaction: both FSMs return to IDLE immediately and any pending response is discarded. A partially latched write is dropped and the RAM is not modified.

Optional Feature:
- Macro DMEM_RANGE_CHECK_EN.
- Defined: an address outside [BASE_ADDR, BASE_ADDR + 4*2**ADDR_W) returns SLVERR (2'b10).
  - Write: RAM unchanged, bresp=SLVERR, same latency as a normal write.
  - Read: rdata=32'h0, rresp=SLVERR, same latency as a normal read.
- Undefined: no check; the index wraps modulo 2**ADDR_W and responses are always OKAY.

Decomposition:
- Shared package dmem_pkg: AXI response constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10) and typedef enums w_state_t and r_state_t.
- One natural sub-module: dmem_ram (byte-enable write port, registered read port, read-first behaviour), instantiated once by dmem_axi_slave.

Test Plan:
- AW 0x10 and W 0xDEADBEEF with strb 4'hF in the same cycle, bready=1 → bvalid exactly 1 cycle later with bresp=00. Then AR 0x10 → rvalid 2 cycles after AR handshake, rdata=0xDEADBEEF.
- W arrives 3 cycles before AW (addr 0x20, data 0x000000AA, strb 4'h1) over existing 0x11223344 → readback 0x112233AA. Verify wready=0 while waiting for AW.
- bready held low 5 cycles → bvalid and bresp held stable. A second AW issued meanwhile is not accepted (awready=0) until the B handshake.
- Read and write to 0x40 (old 0x1, new 0x2) hitting the RAM on the same edge → read returns 0x1; a subsequent read returns 0x2.
- rready held low 4 cycles → rdata stable. Then assert rst_n=0 mid-R_RESP → rvalid=0 immediately, arready=1 after release.
- DMEM_RANGE_CHECK_EN with ADDR_W=12: write to 0x4000 → bresp=10 and word 0 unchanged; read of 0x4000 → rresp=10, rdata=0.
